// File: rtl/colour_arb_ctrl_if.sv
// Requester, detector and status bundle for colour_arb_ctrl.
interface colour_arb_ctrl_if #(
    parameter int unsigned LW = 7,
    parameter int unsigned CW = 8
);
    logic          req0_valid;
    logic [LW-1:0] req0_letter;
    logic          req0_last;
    logic          req0_ready;
    logic          req1_valid;
    logic [LW-1:0] req1_letter;
    logic          req1_last;
    logic          req1_ready;

    logic          det_clr;
    logic [LW-1:0] det_letter;
    logic          det_hit;

    logic          done_valid;
    logic          done_id;
    logic [3:0]    done_hits;
    logic [CW-1:0] hit_cnt0;
    logic [CW-1:0] hit_cnt1;
    logic          gap_err0;
    logic          gap_err1;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_letter, req0_last,
        input  req1_valid, req1_letter, req1_last,
        input  det_hit,
        output req0_ready, req1_ready,
        output det_clr, det_letter,
        output done_valid, done_id, done_hits,
        output hit_cnt0, hit_cnt1, gap_err0, gap_err1
    );

    // Requester / detector / observer side.
    modport master (
        output req0_valid, req0_letter, req0_last,
        output req1_valid, req1_letter, req1_last,
        output det_hit,
        input  req0_ready, req1_ready,
        input  det_clr, det_letter,
        input  done_valid, done_id, done_hits,
        input  hit_cnt0, hit_cnt1, gap_err0, gap_err1
    );
endinterface

// File: rtl/colour_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a shared colour detector,
// counting detector hits per packet and per requester.
module colour_arb_ctrl #(
    parameter int unsigned LW = 7,
    parameter int unsigned CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    colour_arb_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN1,
        DRAIN2,
        DONE
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic [3:0]    pkt_q, pkt_d;
    logic          det_clr_q, det_clr_d;
    logic [LW-1:0] det_letter_q, det_letter_d;
    logic [1:0]    ready_q, ready_d;
    logic          done_valid_q, done_valid_d;
    logic          done_id_q, done_id_d;
    logic [3:0]    done_hits_q, done_hits_d;
    logic [CW-1:0] hit_cnt0_q, hit_cnt0_d;
    logic [CW-1:0] hit_cnt1_q, hit_cnt1_d;
    logic [1:0]    gap_err_q, gap_err_d;

    logic          own_valid;
    logic          own_last;
    logic [LW-1:0] own_letter;
    logic          accept;
    logic          hit_en;
    logic          grant;
    logic [3:0]    pkt_inc;

    // Owner-side mux, handshake, hit qualification and tie-break winner.
    always_comb begin
        own_valid  = owner_q ? bus.req1_valid  : bus.req0_valid;
        own_last   = owner_q ? bus.req1_last   : bus.req0_last;
        own_letter = owner_q ? bus.req1_letter : bus.req0_letter;
        accept     = (state_q == STREAM) && own_valid && ready_q[owner_q];
        hit_en     = bus.det_hit &&
                     ((state_q == STREAM) || (state_q == DRAIN1) || (state_q == DRAIN2));
        grant      = (bus.req0_valid && bus.req1_valid) ? ~rr_last_q : bus.req1_valid;
        pkt_inc    = (pkt_q == 4'hF) ? pkt_q : pkt_q + 4'd1;
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        pkt_d        = pkt_q;
        det_clr_d    = 1'b0;
        det_letter_d = '0;
        ready_d      = 2'b00;
        done_valid_d = 1'b0;
        done_id_d    = done_id_q;
        done_hits_d  = done_hits_q;
        hit_cnt0_d   = hit_cnt0_q;
        hit_cnt1_d   = hit_cnt1_q;
        gap_err_d    = gap_err_q;

        if (hit_en) begin
            pkt_d = pkt_inc;
            if (owner_q) begin
                hit_cnt1_d = (hit_cnt1_q == CNT_MAX) ? hit_cnt1_q : hit_cnt1_q + CW'(1);
            end else begin
                hit_cnt0_d = (hit_cnt0_q == CNT_MAX) ? hit_cnt0_q : hit_cnt0_q + CW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    owner_d   = grant;
                    rr_last_d = grant;
                    det_clr_d = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                ready_d[owner_q] = 1'b1;
                state_d          = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    det_letter_d = own_letter;
                    if (own_last) begin
                        state_d = DRAIN1;
                    end else begin
                        ready_d[owner_q] = 1'b1;
                    end
                end else begin
                    // Bubble: detector sees NUL, packet keeps going.
                    gap_err_d[owner_q] = 1'b1;
                    ready_d[owner_q]   = 1'b1;
                end
            end
            DRAIN1: begin
                state_d = DRAIN2;
            end
            DRAIN2: begin
                // Last detector hit of the packet can still land this cycle.
                state_d      = DONE;
                done_valid_d = 1'b1;
                done_id_d    = owner_q;
                done_hits_d  = pkt_d;
            end
            DONE: begin
                pkt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            pkt_q        <= '0;
            det_clr_q    <= 1'b0;
            det_letter_q <= '0;
            ready_q      <= 2'b00;
            done_valid_q <= 1'b0;
            done_id_q    <= 1'b0;
            done_hits_q  <= '0;
            hit_cnt0_q   <= '0;
            hit_cnt1_q   <= '0;
            gap_err_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            pkt_q        <= pkt_d;
            det_clr_q    <= det_clr_d;
            det_letter_q <= det_letter_d;
            ready_q      <= ready_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
            done_hits_q  <= done_hits_d;
            hit_cnt0_q   <= hit_cnt0_d;
            hit_cnt1_q   <= hit_cnt1_d;
            gap_err_q    <= gap_err_d;
        end
    end

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.det_clr    = det_clr_q;
    assign bus.det_letter = det_letter_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_hits  = done_hits_q;
    assign bus.hit_cnt0   = hit_cnt0_q;
    assign bus.hit_cnt1   = hit_cnt1_q;
    assign bus.gap_err0   = gap_err_q[0];
    assign bus.gap_err1   = gap_err_q[1];

endmodule

// File: tb/tb_colour_arb_ctrl.sv
// Directed bench for colour_arb_ctrl: two identically driven instances
// (CW=8 and CW=2) sharing one behavioural COLOR/COLOUR detector.
module tb_colour_arb_ctrl;

    localparam logic [6:0] CH_C = 7'h43;
    localparam logic [6:0] CH_O = 7'h4F;
    localparam logic [6:0] CH_L = 7'h4C;
    localparam logic [6:0] CH_U = 7'h55;
    localparam logic [6:0] CH_R = 7'h52;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic [6:0] r0_letter = '0, r1_letter = '0;
    logic       r0_last = 1'b0, r1_last = 1'b0;
    logic       det_hit_r = 1'b0;
    int         dst = 0;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         clr_cnt = 0;
    int         stream_seen = 0;
    logic [6:0] exp_letter = '0;
    bit         gap_next = 1'b0;
    int         q0[$];
    int         q1[$];
    int         dn_id[$];
    int         dn_hits[$];
    int         dn_lat[$];
    int         exp_b[5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    colour_arb_ctrl_if #(.LW(7), .CW(8)) if_a ();
    colour_arb_ctrl_if #(.LW(7), .CW(2)) if_b ();

    assign if_a.req0_valid  = r0_valid;
    assign if_a.req0_letter = r0_letter;
    assign if_a.req0_last   = r0_last;
    assign if_a.req1_valid  = r1_valid;
    assign if_a.req1_letter = r1_letter;
    assign if_a.req1_last   = r1_last;
    assign if_a.det_hit     = det_hit_r;
    assign if_b.req0_valid  = r0_valid;
    assign if_b.req0_letter = r0_letter;
    assign if_b.req0_last   = r0_last;
    assign if_b.req1_valid  = r1_valid;
    assign if_b.req1_letter = r1_letter;
    assign if_b.req1_last   = r1_last;
    assign if_b.det_hit     = det_hit_r;

    colour_arb_ctrl #(.LW(7), .CW(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    colour_arb_ctrl #(.LW(7), .CW(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    function automatic int det_next(input int st, input logic [6:0] l);
        if (l == CH_C) return 1;
        if (st == 1 && l == CH_O) return 2;
        if (st == 2 && l == CH_L) return 3;
        if (st == 3 && l == CH_O) return 4;
        if (st == 4 && l == CH_U) return 5;
        return 0;
    endfunction

    // Behavioural detector: HIT one cycle after consuming the R of COLOR/COLOUR.
    always @(posedge clk) begin
        if (rst || if_a.det_clr) begin
            dst       <= 0;
            det_hit_r <= 1'b0;
        end else begin
            det_hit_r <= (if_a.det_letter == CH_R) && (dst == 4 || dst == 5);
            dst       <= det_next(dst, if_a.det_letter);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_str(input int n, input string s, input bit term);
        for (int i = 0; i < s.len(); i++) begin
            int it;
            it = int'(s[i]) & 'h7F;
            if (term && i == s.len() - 1) it = it | 'h80;
            if (n == 0) q0.push_back(it); else q1.push_back(it);
        end
    endtask

    task automatic drv(input bit has, input int it, input logic rdy,
                       output logic v, output logic [6:0] l, output logic la, output bit pop);
        v = 1'b0; l = '0; la = 1'b0; pop = 1'b0;
        if (has) begin
            if (it >= 0) begin
                v  = 1'b1;
                l  = it[6:0];
                la = it[7];
            end
            pop = rdy && !rst;
        end
    endtask

    // One clock: check previous edge's results, then drive the next edge.
    task automatic step(input bit r);
        bit p;
        int h;
        @(negedge clk);
        cyc++;
        check_eq("det_letter", 32'(if_a.det_letter), 32'(exp_letter));
        if (gap_next) check_eq("gap_letter", 32'(if_a.det_letter), 0);
        check_eq("ready_excl", 32'(if_a.req0_ready & if_a.req1_ready), 0);
        if (if_a.det_clr) clr_cnt++;
        if (if_a.req0_ready | if_a.req1_ready) stream_seen++;
        if (if_a.done_valid) begin
            dn_id.push_back(int'(if_a.done_id));
            dn_hits.push_back(int'(if_a.done_hits));
            dn_lat.push_back(cyc - last_acc_cyc);
        end
        exp_letter = '0;
        gap_next   = 1'b0;
        rst        = r;
        h = (q0.size() > 0) ? q0[0] : 0;
        drv(q0.size() > 0, h, if_a.req0_ready, r0_valid, r0_letter, r0_last, p);
        if (p) begin
            if (h >= 0) begin
                exp_letter = h[6:0];
                if (h[7]) last_acc_cyc = cyc;
            end else gap_next = 1'b1;
            void'(q0.pop_front());
        end
        h = (q1.size() > 0) ? q1[0] : 0;
        drv(q1.size() > 0, h, if_a.req1_ready, r1_valid, r1_letter, r1_last, p);
        if (p) begin
            if (h >= 0) begin
                exp_letter = h[6:0];
                if (h[7]) last_acc_cyc = cyc;
            end else gap_next = 1'b1;
            void'(q1.pop_front());
        end
    endtask

    task automatic run_until(input int n);
        int k = 0;
        while (dn_id.size() < n && k < 200) begin
            step(1'b0);
            k++;
        end
        check_eq("done_timeout", 32'(dn_id.size() >= n), 1);
    endtask

    task automatic chk_done(input int id, input int hits);
        if (dn_id.size() > 0) begin
            check_eq("done_id", dn_id.pop_front(), id);
            check_eq("done_hits", dn_hits.pop_front(), hits);
            check_eq("done_latency", dn_lat.pop_front(), 3);
        end else begin
            check_eq("done_missing", 0, 1);
        end
    endtask

    task automatic do_reset();
        step(1'b1);
        step(1'b1);
        dn_id.delete();
        dn_hits.delete();
        dn_lat.delete();
        clr_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        do_reset();
        step(1'b0);
        check_eq("rst_ready", {if_a.req0_ready, if_a.req1_ready}, 0);
        check_eq("rst_det_clr", 32'(if_a.det_clr), 0);
        check_eq("rst_done_valid", 32'(if_a.done_valid), 0);
        check_eq("rst_done_fields", {if_a.done_id, if_a.done_hits}, 0);
        check_eq("rst_hit_cnt", {if_a.hit_cnt0, if_a.hit_cnt1}, 0);
        check_eq("rst_gap_err", {if_a.gap_err0, if_a.gap_err1}, 0);

        // COLOR from req0.
        push_str(0, "COLOR", 1'b1);
        run_until(1);
        chk_done(0, 1);
        check_eq("clr_pulses", clr_cnt, 1);
        check_eq("hit_cnt0_a", 32'(if_a.hit_cnt0), 1);
        repeat (3) step(1'b0);
        check_eq("done_valid_strobe", 32'(if_a.done_valid), 0);
        check_eq("done_hits_hold", 32'(if_a.done_hits), 1);
        check_eq("done_id_hold", 32'(if_a.done_id), 0);

        // COLOURCOLOR from req1.
        push_str(1, "COLOURCOLOR", 1'b1);
        run_until(1);
        chk_done(1, 2);
        check_eq("hit_cnt1_a", 32'(if_a.hit_cnt1), 2);
        check_eq("hit_cnt0_keep", 32'(if_a.hit_cnt0), 1);
        check_eq("gap_err1_clean", 32'(if_a.gap_err1), 0);

        // COL, bubble, OR from req0.
        push_str(0, "COL", 1'b0);
        q0.push_back(-1);
        push_str(0, "OR", 1'b1);
        run_until(1);
        chk_done(0, 0);
        check_eq("gap_err0_set", 32'(if_a.gap_err0), 1);
        check_eq("gap_err1_clear", 32'(if_a.gap_err1), 0);

        // Single-letter packet from req1.
        push_str(1, "R", 1'b1);
        run_until(1);
        chk_done(1, 0);
        check_eq("gap_err0_sticky", 32'(if_a.gap_err0), 1);

        // Simultaneous requests right after reset, twice.
        do_reset();
        push_str(0, "COLOR", 1'b1);
        push_str(1, "COLOR", 1'b1);
        run_until(2);
        chk_done(0, 1);
        chk_done(1, 1);
        push_str(0, "COLOR", 1'b1);
        push_str(1, "COLOR", 1'b1);
        run_until(2);
        chk_done(0, 1);
        chk_done(1, 1);
        check_eq("tie_hit_cnt0", 32'(if_a.hit_cnt0), 2);
        check_eq("tie_hit_cnt1", 32'(if_a.hit_cnt1), 2);
        check_eq("gap_err0_rst", 32'(if_a.gap_err0), 0);

        // Reset in the 3rd STREAM cycle.
        do_reset();
        push_str(0, "COLOR", 1'b1);
        stream_seen = 0;
        for (int k = 0; k < 20 && stream_seen < 2; k++) step(1'b0);
        step(1'b1);
        step(1'b0);
        check_eq("mid_rst_ready", {if_a.req0_ready, if_a.req1_ready}, 0);
        check_eq("mid_rst_det", {if_a.det_clr, if_a.det_letter}, 0);
        check_eq("mid_rst_done", {if_a.done_valid, if_a.done_id, if_a.done_hits}, 0);
        check_eq("mid_rst_cnt", {if_a.hit_cnt0, if_a.hit_cnt1, if_a.gap_err0, if_a.gap_err1}, 0);
        check_eq("mid_rst_no_done", dn_id.size(), 0);
        check_eq("mid_rst_pending", q0.size(), 3);
        run_until(1);
        chk_done(0, 0);
        push_str(0, "COLOR", 1'b1);
        run_until(1);
        chk_done(0, 1);
        check_eq("post_rst_hit_cnt0", 32'(if_a.hit_cnt0), 1);

        // Saturation of a 2-bit requester counter.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            push_str(0, "COLOR", 1'b1);
            run_until(1);
            chk_done(0, 1);
            check_eq("cw2_hit_cnt0", 32'(if_b.hit_cnt0), exp_b[p]);
            check_eq("cw8_hit_cnt0", 32'(if_a.hit_cnt0), p + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/colour_arb_ctrl.md
COLOUR_ARB_CTRL -- requirements
Module: colour_arb_ctrl

Parameters
REQ-001 The block SHALL take parameter LW, default 7, as the ASCII letter width.
REQ-002 The block SHALL take parameter CW, default 8, as the per-requester total hit counter width.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 reqN_valid  input  1  requester N (N=0,1) offers a letter.
REQ-006 reqN_letter  input  LW  requester N letter, ASCII.
REQ-007 reqN_last  input  1  requester N letter is the last of its packet.
REQ-008 reqN_ready  output  1  requester N letter accepted this cycle when valid also high.
REQ-009 det_clr  output  1  clear pulse to the shared colour detector.
REQ-010 det_letter  output  LW  registered letter driven to the detector; 7'h00 (NUL) when no letter.
REQ-011 det_hit  input  1  detector HIT, high one cycle after the detector consumes the final R.
REQ-012 done_valid  output  1  one-cycle packet-complete strobe.
REQ-013 done_id  output  1  requester that owned the completed packet.
REQ-014 done_hits  output  4  hits in the completed packet, saturating at 15.
REQ-015 hit_cntN  output  CW  total hits credited to requester N, saturating at 2^CW-1.
REQ-016 gap_errN  output  1  sticky flag: requester N stalled mid-packet.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, STREAM, DRAIN1, DRAIN2, DONE.
REQ-018 IDLE: if any reqN_valid, grant round-robin (the requester not granted last wins a tie), latch owner, go to CLEAR; else stay.
REQ-019 CLEAR: det_clr=1 for exactly this cycle; next state STREAM.
REQ-020 STREAM: only owner's reqN_ready=1; the other ready SHALL be 0; the letter is not consumed from the requester before grant.
REQ-021 On an accepted letter, det_letter SHALL equal that letter in the next cycle (1-cycle latency).
REQ-022 STREAM with owner valid=0 (bubble): det_letter next cycle SHALL be 7'h00, gap_err[owner] set; packet continues.
REQ-023 Accepted letter with last=1 SHALL move to DRAIN1; DRAIN1 -> DRAIN2 -> DONE unconditionally.
REQ-024 det_letter SHALL be 7'h00 in every cycle not directly following an accepted letter.
REQ-025 The packet hit count SHALL increment (saturating at 15) on every cycle det_hit=1 in STREAM, DRAIN1 or DRAIN2; det_hit in other states SHALL be ignored.
REQ-026 Each counted hit SHALL also increment hit_cnt[owner], saturating at 2^CW-1.
REQ-027 DONE: done_valid=1, done_id=owner, done_hits=packet count for one cycle; the packet count clears; next state IDLE.
REQ-028 done_valid SHALL rise exactly 3 cycles after the cycle the last letter was accepted.
REQ-029 done_id and done_hits SHALL hold their values until the next DONE.
REQ-030 A single-letter packet (valid and last together) SHALL follow the same path; done_hits=0.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, round-robin pointer so req0 wins the next tie, and the packet count to 0.
REQ-032 The same edge SHALL set det_letter=7'h00 and det_clr=0.
REQ-033 The same edge SHALL clear done_valid, done_id, done_hits, all hit_cntN and all gap_errN to 0; reqN_ready SHALL be 0.
REQ-034 Reset mid-packet SHALL abandon the packet without a done strobe; the requester keeps its letter pending.
REQ-035 gap_errN SHALL clear only on reset.

Verification
REQ-036 req0 sends "COLOR", last on R, with a behavioural detector -> det_clr pulse, done_valid 3 cycles after R, done_id=0, done_hits=1, hit_cnt0=1.
REQ-037 Both requesters valid in the first cycle after reset -> req0 served first, then req1; a second simultaneous pair -> req0 first again.
REQ-038 req1 sends "COLOURCOLOR" -> done_hits=2, hit_cnt1=2, gap_err1=0.
REQ-039 req0 sends "COL", one bubble, "OR" -> det_letter shows 7'h00 in the gap; done_hits=0; gap_err0=1 until reset.
REQ-040 rst in the 3rd STREAM cycle -> next cycle all outputs at reset values; no done_valid; a fresh packet then completes normally.
REQ-041 With CW=2, req0 sends five "COLOR" packets -> hit_cnt0 reads 1, 2, 3, 3, 3.
